// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  // Single access-error code; kept as a constant so rsp_err can widen later.
  localparam logic ERR_ACCESS = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, synchronous clear, and a read-capture
// register loaded when a request is accepted.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  cap_en,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: clearing every word on reset forces the array into flops; a
      // RAM macro could not honour this, which is accepted for this size.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (wr_en) begin
        mem[idx] <= wdata;
      end
      if (cap_en) begin
        rdata <= rd_en ? mem[idx] : '0;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word request, fixed access latency,
// valid/ready on both channels, misaligned/out-of-range error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              err_q;
  logic [31:0]       offset;
  logic              dec_err;
  logic              accept;
  logic [WORD_W-1:0] cap_data;

  // BASE_ADDR is aligned, so the low offset bits equal the address low bits.
  assign offset  = req_addr - BASE_ADDR;
  assign dec_err = (offset[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                   ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_ready && req_valid;

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a latch.
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        err_q <= dec_err;
      end
    end
  end

  // Response fields are masked outside RESP so they only appear on entry.
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (rsp_valid && err_q) ? ERR_ACCESS : 1'b0;
  assign rsp_rdata = rsp_valid ? cap_data : '0;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (accept && req_wen && !dec_err),
    .cap_en(accept),
    .rd_en (!req_wen && !dec_err),
    .idx   (offset[DEPTH_LOG2+1:2]),
    .wdata (req_wdata),
    .rdata (cap_data)
  );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (slave) for the CPU data port. It serves word read/write requests with a configurable access latency, a valid/ready handshake on both channels, and error reporting.
- Serves as the memory end of the mem_D interface once the core moves from a zero-latency memory model to a multi-cycle one.
- Holds one outstanding request; backpressures the requester while busy.
- Storage is an internal register array; words are stored and returned in bus byte order with no byte swapping inside the block.

Parameters:
- DEPTH_LOG2, 8, log2 of word count (256 words = 1 KiB).
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  access error (misaligned or out of range).

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - FSM to IDLE.
  - req_ready=0 during the reset cycle, 1 in IDLE afterwards.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency counter=0.
  - All storage words cleared to 0.
- Reset mid-operation: any in-flight request is dropped with no response. A write already committed at accept stays committed unless reset clears the array; reset always clears it.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid=1, the request is accepted at that edge and the FSM goes to WAIT with the counter loaded to LATENCY-1. If LATENCY=1, it goes directly to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0 the FSM goes to RESP.
  - RESP: rsp_valid=1, outputs held stable. On rsp_ready=1 the FSM goes to IDLE.
  - Handshake rules: no new accept in WAIT or RESP. req_ready depends on state only, never combinationally on req_valid.
- Latency: accept at edge T gives rsp_valid=1 in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after accept. rsp_ready may already be 1 when rsp_valid rises; the response then completes in one cycle and req_ready=1 in the following cycle.
- Address decode:
  - Word index = (req_addr - BASE_ADDR) >> 2.
  - Error if req_addr[1:0] != 0, or req_addr < BASE_ADDR, or index >= 2^DEPTH_LOG2. Subtraction is 32-bit unsigned.
- Access timing:
  - Write: committed to the array at the accept edge.
  - Read: data captured into the response register at the accept edge.
  - Because only one request is outstanding, a read after a write returns the new data.
- Error access: no array update. Response carries rsp_err=1, rsp_rdata=0, and still takes LATENCY cycles.
- Write response: rsp_rdata=0, rsp_err=0 unless errored.
- rsp_rdata and rsp_err change only on entry to RESP. They stay stable while rsp_valid=1 and rsp_ready=0, and are cleared to 0 on leaving RESP.
- Changes on req_* inputs in WAIT or RESP are ignored.

Decomposition:
- Shared package `dmem_pkg`:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - WORD_W=32.
  - Localparam for the counter width (4 bits).
  - Error-code constant reserved for a future rsp_err widening.
- One natural sub-module: `dmem_array`, the storage with synchronous write, synchronous clear, and registered read capture. The FSM, address decode and counter stay in dmem_responder.

Test Plan:
- Reset then idle, LATENCY=2: after rst_n rises, req_ready=1, rsp_valid=0, rsp_rdata=0; reading address 0x10 returns rsp_rdata=0, rsp_err=0.
- Write then read, LATENCY=2:
  - Write 0xDEADBEEF to 0x20, accepted at cycle T; rsp_valid=1 at T+2 with rsp_rdata=0, rsp_err=0.
  - Read 0x20 returns 0xDEADBEEF after exactly 2 cycles.
- Backpressure: read 0x20 with rsp_ready=0 for 5 cycles. rsp_valid stays 1, rsp_rdata stays 0xDEADBEEF, req_ready stays 0 throughout, and a req_valid pulse to 0x24 during this time is not accepted.
- Errors:
  - Write to 0x22 (misaligned) gives rsp_err=1, and a later read of 0x20 still returns 0xDEADBEEF.
  - Read of 0x400 (index 256 at DEPTH_LOG2=8) gives rsp_err=1, rsp_rdata=0.
- Back-to-back at LATENCY=1 with rsp_ready tied to 1: one accept every 2 cycles. Writing 0x1, 0x2, 0x3 to 0x0, 0x4, 0x8 and reading them back returns 1, 2, 3 in order.
- Reset mid-WAIT, LATENCY=4: assert rst_n=0 two cycles after accepting a write of 0x55 to 0x30. No response is produced, and the next read of 0x30 returns 0.
